shared_counter_arbiter: RTL and testbench
=========================================

SHARED_COUNTER_ARBITER -- requirements
Module: shared_counter_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, SHALL set the shared counter width.
REQ-003 clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  SHALL carry one request-valid bit per requester.
REQ-006 req_ready  output  NUM_REQ  SHALL carry a one-hot accept strobe per requester.
REQ-007 req_op  input  2*NUM_REQ  SHALL carry per-requester opcode: 00 INC, 01 ADD, 10 LOAD, 11 CLEAR.
REQ-008 req_data  input  WIDTH*NUM_REQ  SHALL carry per-requester operand; requester i occupies slice i.
REQ-009 resp_valid  output  1  SHALL flag a valid response.
REQ-010 resp_id  output  max(1,$clog2(NUM_REQ))  SHALL carry the index of the served requester.
REQ-011 resp_data  output  WIDTH  SHALL carry the counter value after the operation.
REQ-012 resp_ovf  output  1  SHALL flag that the served INC/ADD overflowed.
REQ-013 resp_ready  input  1  SHALL indicate that the response consumer accepts.
REQ-014 cnt_value  output  WIDTH  SHALL carry the live registered counter value.
REQ-015 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-017 In IDLE, req_ready SHALL be combinationally one-hot on the round-robin winner among req_valid, else all zero.
REQ-018 Round-robin search SHALL start at last_grant+1 modulo NUM_REQ.
REQ-019 A handshake (req_valid[i] and req_ready[i]) SHALL capture op, data and index, update last_grant to i, and move IDLE to EXEC.
REQ-020 req_ready SHALL be all zero in EXEC and RESP; requests there wait, with no loss and no reordering.
REQ-021 In EXEC, the counter SHALL update: INC +1, ADD +operand, LOAD = operand, CLEAR = 0; the state SHALL then move to RESP.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH; overflow is the carry out of the WIDTH-bit add, and LOAD/CLEAR never overflow.
REQ-023 Entering RESP, resp_valid SHALL rise with resp_id, resp_data and resp_ovf registered; all SHALL be held stable until resp_ready.
REQ-024 RESP with resp_ready high SHALL return to IDLE the next cycle; resp_valid SHALL drop in that same cycle.
REQ-025 Latency SHALL be: accept at cycle T, counter updated at T+2, resp_valid high at T+2; minimum issue interval is 3 cycles.
REQ-026 A single persistent requester SHALL be re-granted whenever it is the only valid one.
REQ-027 Under full load, each requester SHALL be granted exactly once per NUM_REQ grants.
REQ-028 resp_ready sampled outside RESP SHALL be ignored.

Reset
REQ-029 rst_n low at a clock edge SHALL force state IDLE, counter 0 and last_grant NUM_REQ-1, so requester 0 is first.
REQ-030 During reset, req_ready, resp_valid, resp_ovf, resp_id and resp_data SHALL be 0.
REQ-031 Reset in EXEC or RESP SHALL discard the pending operation; no response is issued for it.

Configuration
REQ-032 With SHARED_CNT_SATURATE_EN defined, an overflowing INC/ADD SHALL clamp the counter to 2^WIDTH-1 and still assert resp_ovf.
REQ-033 Without SHARED_CNT_SATURATE_EN, the counter SHALL wrap modulo 2^WIDTH with resp_ovf asserted.

Verification
REQ-034 The bench SHALL run: reset, then req0 LOAD 0x10 -> resp_id 0, resp_data 0x10, resp_ovf 0, with resp_valid exactly 2 cycles after accept.
REQ-035 The bench SHALL run: all four requesters continuously issuing INC from 0 -> grant order 0,1,2,3,0 with resp_data 1,2,3,4,5.
REQ-036 The bench SHALL run: LOAD 0xFE then ADD 0x05 -> without the macro resp_data 0x03, resp_ovf 1; with the macro resp_data 0xFF, resp_ovf 1.
REQ-037 The bench SHALL run: resp_ready held low for 5 cycles -> resp_valid and resp fields stable for 5 cycles, req_ready all zero, and the new request not accepted until the state returns to IDLE.
REQ-038 The bench SHALL run: rst_n asserted in EXEC of an ADD 0x20 -> no response, cnt_value 0, and the next grant goes to requester 0.
REQ-039 The bench SHALL run: CLEAR from req2 while cnt_value is 0x7A -> resp_data 0x00, resp_id 2, resp_ovf 0.

Source files
------------

// File: rtl/shared_counter_arbiter.sv
// Round-robin arbiter that serialises INC/ADD/LOAD/CLEAR operations onto one shared counter.
// Define SHARED_CNT_SATURATE_EN to clamp overflowing INC/ADD at all-ones instead of wrapping.
module shared_counter_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int IDW     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_data,
  output logic                     resp_valid,
  output logic [IDW-1:0]           resp_id,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     resp_ovf,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         cnt_value,
  output logic                     busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [1:0] OP_INC   = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [WIDTH:0] ONE  = {{WIDTH{1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]     last_q, id_q, resp_id_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   data_q, resp_data_q;
  logic               resp_ovf_q;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx, cand;
  logic               found, accept;
  logic [1:0]         sel_op;
  logic [WIDTH-1:0]   sel_data;
  logic [WIDTH:0]     sum;
  logic               ovf;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((32'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_op   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op   = req_op[2*i +: 2];
        sel_data = req_data[WIDTH*i +: WIDTH];
      end
    end
  end

  assign accept = found && (state_q == S_IDLE) && rst_n;

  always_comb begin
    sum   = '0;
    ovf   = 1'b0;
    cnt_d = '0;
    unique case (op_q)
      OP_INC, OP_ADD: begin
        sum   = {1'b0, cnt_q} + ((op_q == OP_INC) ? ONE : {1'b0, data_q});
        ovf   = sum[WIDTH];
`ifdef SHARED_CNT_SATURATE_EN
        cnt_d = ovf ? '1 : sum[WIDTH-1:0];
`else
        cnt_d = sum[WIDTH-1:0];
`endif
      end
      OP_LOAD: cnt_d = data_q;
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      last_q      <= IDW'(NUM_REQ - 1);
      op_q        <= '0;
      data_q      <= '0;
      id_q        <= '0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
      resp_ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= sel_op;
        data_q <= sel_data;
        id_q   <= grant_idx;
        last_q <= grant_idx;
      end
      if (state_q == S_EXEC) begin
        cnt_q       <= cnt_d;
        resp_id_q   <= id_q;
        resp_data_q <= cnt_d;
        resp_ovf_q  <= ovf;
      end
    end
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE && rst_n) ? grant : '0;
    resp_valid = (state_q == S_RESP) && rst_n;
    busy       = (state_q != S_IDLE);
    resp_id    = resp_id_q;
    resp_data  = resp_data_q;
    resp_ovf   = resp_ovf_q;
    cnt_value  = cnt_q;
  end

endmodule

// File: tb/tb_shared_counter_arbiter.sv
// Randomised and directed bench for shared_counter_arbiter against a transaction-level model.
module tb_shared_counter_arbiter;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;
  localparam int MAXV = (1 << W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready;
  logic [2*N-1:0]   req_op;
  logic [W*N-1:0]   req_data;
  logic             resp_valid, resp_ovf, resp_ready, busy;
  logic [IDW-1:0]   resp_id;
  logic [W-1:0]     resp_data, cnt_value;

  always #5 clk = ~clk;

  shared_counter_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_ovf(resp_ovf),
    .resp_ready(resp_ready), .cnt_value(cnt_value), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  logic [N-1:0] pend_v;
  logic [1:0]   pend_op   [N];
  logic [W-1:0] pend_data [N];

  int cnt_m, last_m, age, exp_id, exp_res, exp_ovf;
  bit inflight, taken, persist, rand_fill;
  int cyc, acc_cyc, rise_cyc;
  logic prev_rv;
  logic [W-1:0] h_data;
  logic [IDW-1:0] h_id;

  typedef struct { int id; int data; int ovf; } resp_t;
  resp_t resp_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Next winner: lowest valid index above the last grant, else lowest valid index overall.
  function automatic int winner(input logic [N-1:0] v, input int last);
    for (int i = last + 1; i < N; i++) if (v[i]) return i;
    for (int i = 0; i <= last; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic predict(input int id, input int op, input int d);
    int s;
    case (op)
      0:       s = cnt_m + 1;
      1:       s = cnt_m + d;
      2:       s = d;
      default: s = 0;
    endcase
    exp_ovf = (op < 2 && s > MAXV) ? 1 : 0;
`ifdef SHARED_CNT_SATURATE_EN
    if (s > MAXV) s = MAXV;
`else
    if (s > MAXV) s = s - (MAXV + 1);
`endif
    exp_res = s;
    exp_id  = id;
  endtask

  task automatic pend(input int i, input int op, input int d);
    pend_v[i]    = 1'b1;
    pend_op[i]   = 2'(op);
    pend_data[i] = W'(d);
  endtask

  task automatic step(input logic rdy);
    int w;
    logic [N-1:0] er;
    bit shown;
    @(posedge clk); #1;
    cyc++;
    if (taken) inflight = 0;
    else if (inflight) begin
      age++;
      if (age == 2) cnt_m = exp_res;
    end
    taken = 0;
    req_valid = pend_v;
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2]  = pend_op[i];
      req_data[W*i +: W] = pend_data[i];
    end
    resp_ready = rdy;
    @(negedge clk);
    w  = inflight ? -1 : winner(pend_v, last_m);
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    shown = inflight && age >= 2;
    check("req_ready", req_ready, er);
    check("busy", busy, inflight);
    check("resp_valid", resp_valid, shown);
    if (shown) begin
      check("resp_id", resp_id, exp_id);
      check("resp_data", resp_data, exp_res);
      check("resp_ovf", resp_ovf, exp_ovf);
    end
    check("cnt_value", cnt_value, cnt_m);
    if (|(req_ready & req_valid)) acc_cyc = cyc;
    if (resp_valid && !prev_rv) rise_cyc = cyc;
    prev_rv = resp_valid;
    if (resp_valid && resp_ready)
      resp_log.push_back('{int'(resp_id), int'(resp_data), int'(resp_ovf)});
    if (w >= 0) begin
      predict(w, int'(pend_op[w]), int'(pend_data[w]));
      inflight = 1; age = 0; last_m = w;
      if (!persist) pend_v[w] = 1'b0;
    end
    if (shown && rdy) taken = 1;
    if (rand_fill)
      for (int i = 0; i < N; i++)
        if (!pend_v[i] && $urandom_range(0, 3) == 0)
          pend(i, int'($urandom_range(0, 3)), int'($urandom_range(0, MAXV)));
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = '1; resp_ready = 1'b1;
    req_op = 8'h1B;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_id", resp_id, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_resp_ovf", resp_ovf, 0);
      check("rst_cnt", cnt_value, 0);
      check("rst_busy", busy, 0);
    end
    rst_n = 1'b1; req_valid = '0; resp_ready = 1'b0;
    cnt_m = 0; last_m = N - 1; inflight = 0; taken = 0; pend_v = '0; prev_rv = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget);
    int b;
    b = 0;
    while (resp_log.size() < n && b < budget) begin
      step(1'b1);
      b++;
    end
    if (resp_log.size() < n) check("timeout", resp_log.size(), n);
  endtask

  task automatic check_resp(input int k, input int id, input int data, input int ovf);
    if (k < resp_log.size()) begin
      check("log_id", resp_log[k].id, id);
      check("log_data", resp_log[k].data, data);
      check("log_ovf", resp_log[k].ovf, ovf);
    end else check("log_missing", resp_log.size(), k + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int ovf_res;
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_data = '0; resp_ready = 1'b0;
    pend_v = '0; persist = 0; rand_fill = 0; cyc = 0; acc_cyc = 0; rise_cyc = 0;
    for (int i = 0; i < N; i++) begin pend_op[i] = '0; pend_data[i] = '0; end
    do_reset(2);

    resp_log.delete();
    pend(0, 2, 'h10);
    run_until(1, 20);
    check_resp(0, 0, 'h10, 0);
    check("latency", rise_cyc - acc_cyc, 2);

    do_reset(1);
    resp_log.delete();
    persist = 1;
    for (int i = 0; i < N; i++) pend(i, 0, 0);
    run_until(5, 60);
    persist = 0; pend_v = '0;
    for (int k = 0; k < 5; k++) check_resp(k, k % N, k + 1, 0);

    resp_log.delete();
    pend(1, 2, 'hFE);
    run_until(1, 20);
    pend(3, 1, 'h05);
    run_until(2, 20);
`ifdef SHARED_CNT_SATURATE_EN
    ovf_res = 'hFF;
`else
    ovf_res = 'h03;
`endif
    check_resp(0, 1, 'hFE, 0);
    check_resp(1, 3, ovf_res, 1);

    resp_log.delete();
    pend(0, 2, 'h7A);
    run_until(1, 20);
    check("cnt_7a", cnt_value, 'h7A);
    pend(2, 3, 0);
    run_until(2, 20);
    check_resp(1, 2, 'h00, 0);

    resp_log.delete();
    pend(2, 0, 0);
    step(1'b0);
    pend(0, 2, 'h33);
    step(1'b0);
    step(1'b0);
    h_data = resp_data; h_id = resp_id;
    check("hold_first", resp_data, 1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      check("hold_valid", resp_valid, 1);
      check("hold_data", resp_data, h_data);
      check("hold_id", resp_id, h_id);
      check("hold_ready", req_ready, 0);
    end
    run_until(2, 20);
    check_resp(0, 2, 1, 0);
    check_resp(1, 0, 'h33, 0);

    resp_log.delete();
    pend(1, 1, 'h20);
    step(1'b1);
    check("exec_accept", req_ready, 4'b0010);
    do_reset(2);
    check("rst_no_resp", resp_log.size(), 0);
    pend(0, 0, 0);
    pend(2, 0, 0);
    step(1'b1);
    check("post_rst_grant", req_ready, 4'b0001);
    run_until(1, 20);
    check_resp(0, 0, 1, 0);

    rand_fill = 1;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset(1);
      step(1'($urandom_range(0, 1)));
    end
    rand_fill = 0;
    for (int i = 0; i < 200 && (inflight || pend_v != '0); i++) step(1'b1);
    check("drain", {31'd0, inflight} | 32'(pend_v), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
